ddr_sdram_local_arbiter: RTL
============================

# ddr_sdram_local_arbiter

Two-port arbiter that shares the single local (user) interface of the DDR SDRAM controller/PHY between two requesters. It sits in the `phy_clk` domain, between the requesters and the controller's `local_*` ports. It registers one command at a time onto the local interface. It buffers write data internally and answers `local_wdata_req` itself. Read returns are routed back to the issuing port in order, using a tag FIFO.

## Interface
Parameters:
- `ADDR_W`, 22: local word address width.
- `DATA_W`, 64: local data width.
- `BE_W`, 8: byte-enable width (`DATA_W/8`).
- `RD_DEPTH`, 8: read tag FIFO depth; power of two, at least 2.
- `WR_DEPTH`, 8: write data FIFO depth; power of two, at least 2.

Ports:
- `phy_clk`, in, 1: the only clock.
- `reset_phy_clk`, in, 1: synchronous, active-high reset.
- `pN_read_req`, `pN_write_req`, in, 1 each (N = 0, 1): request strobes. A port must not assert both in the same cycle.
- `pN_address`, in, `ADDR_W`: request address.
- `pN_wdata`, in, `DATA_W`: write data, sampled with the write request.
- `pN_be`, in, `BE_W`: byte enables, sampled with the write request.
- `pN_ready`, out, 1: the request is accepted in the cycle where the strobe and `pN_ready` are both high.
- `pN_rdata`, out, `DATA_W`: read data returned to port N.
- `pN_rdata_valid`, out, 1: `pN_rdata` is valid this cycle.
- `local_init_done`, in, 1: controller calibration/initialisation complete.
- `local_ready`, in, 1: controller accepts the presented command this cycle.
- `local_read_req`, `local_write_req`, `local_burstbegin`, out, 1 each: command strobes to the controller.
- `local_address`, out, `ADDR_W`: command address.
- `local_size`, out, 1: burst size; tied to 1 (single beat).
- `local_wdata_req`, in, 1: controller requests the next write beat.
- `local_wdata`, out, `DATA_W`: write beat to the controller.
- `local_be`, out, `BE_W`: byte enables for the write beat.
- `local_rdata`, in, `DATA_W`: read data from the controller.
- `local_rdata_valid`, in, 1: `local_rdata` is valid this cycle.
- `err_orphan_rdata`, out, 1: sticky error flag.

## Operation
- **Command stage.** A single register, `cmd_v` plus port, type, address and data.
  - It may load when `cmd_v` is 0, or when `cmd_v` is 1 and `local_ready` is 1 in the same cycle.
  - While `cmd_v` is 1, the controller-side strobes are driven from the register: `local_read_req` or `local_write_req` as per the stored type, with `local_burstbegin` = 1.
  - The command retires on `cmd_v & local_ready`.
- **Eligibility.** A request is eligible only when all of the following hold:
  - `local_init_done` is 1;
  - the command stage can load;
  - for reads, the read tag FIFO is not full;
  - for writes, the write data FIFO is not full.
  - Occupancy counts include entries pushed in the current cycle.
- **Grant.** Exactly one eligible port is granted per cycle; the choice is set by the configuration below. `pN_ready` is 1 only for the granted port and only when that port's request is eligible. It is never 1 when the port is not requesting.
- **Read path.**
  - On accepting a read, push the port ID into the read tag FIFO.
  - On `local_rdata_valid`, pop the FIFO and route the beat to the port at its head.
  - That port's `pN_rdata_valid` is high and `pN_rdata` = `local_rdata`. Both are registered, giving 1 cycle of latency.
  - If `local_rdata_valid` arrives with the tag FIFO empty, the beat is dropped and `err_orphan_rdata` is set. It stays set until reset.
- **Write path.**
  - On accepting a write, push {`wdata`, `be`} into the write data FIFO.
  - On `local_wdata_req`, pop the FIFO. `local_wdata`/`local_be` are registered from the head and presented the cycle after `local_wdata_req`.
  - If `local_wdata_req` arrives with the FIFO empty, nothing is popped, `local_be` = 0, and `err_orphan_rdata` is not affected.
- **Simultaneous push and pop** on either FIFO:
  - occupancy is unchanged;
  - a full FIFO may both pop and push in the same cycle, since pop is evaluated first;
  - pointers wrap modulo depth.
- **Reset values.**
  - All outputs are 0, except `local_size` = 1.
  - FIFOs are empty, `cmd_v` = 0 and `err_orphan_rdata` = 0.
  - The round-robin pointer selects port 0.
- **Reset mid-operation** discards queued commands, tags and write data. Read beats arriving after reset flag `err_orphan_rdata`.

## Timing
- Request accept to `local_*_req` high: 1 cycle, if `local_ready` was high.
- A new command can issue every cycle while `local_ready` stays 1.
- `local_wdata_req` to `local_wdata` valid: 1 cycle.
- `local_rdata_valid` to `pN_rdata_valid`: 1 cycle.
- `pN_ready` is combinational from the `pN_*_req` inputs and internal state. No combinational path runs from any `local_*` input to a `local_*` output.

## Configuration
- `DDR_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - Priority goes to the port that was not granted last.
  - The pointer updates only on an accepted request.
  - With both ports requesting continuously, grants alternate 0,1,0,1.
- Undefined: fixed priority. Port 0 always wins, and port 1 is granted only when port 0 is not requesting.

## Structure
- Shared package `ddr_sdram_arb_pkg` holds:
  - the port-ID typedef (1 bit);
  - the command-type enum (`CMD_RD`, `CMD_WR`);
  - default constants for `ADDR_W`, `DATA_W` and `BE_W`.
- One sub-module, `ddr_sdram_arb_fifo`, is a parameterised synchronous FIFO (width, depth) with full/empty and occupancy count. It is instantiated twice: read tag, and write data plus byte enables.

## Test plan
- Reset, then `local_init_done` = 0 with `p0_read_req` held: `p0_ready` stays 0. After `local_init_done` = 1, `local_read_req` goes high 1 cycle after acceptance with `local_address` = `p0_address`.
- Both ports issuing continuous reads with `local_ready` = 1 under `DDR_ARB_ROUND_ROBIN_EN`:
  - commands alternate p0, p1;
  - returning four `local_rdata_valid` beats 0xA, 0xB, 0xC, 0xD gives p0 0xA and 0xC, and p1 0xB and 0xD.
- Without the macro, the same stimulus gives only p0 grants until `p0_read_req` drops.
- Port 1 issues 8 writes (0x10–0x17) with no `local_wdata_req`: the ninth write is refused (`p1_ready` = 0). Eight `local_wdata_req` pulses then produce 0x10..0x17 in order, each 1 cycle after its request.
- `local_ready` = 0 for 5 cycles with a command pending: the strobes and address hold steady, and no further `pN_ready` is given.
- `local_rdata_valid` pulse with no outstanding reads: `err_orphan_rdata` goes to 1 and stays there, and no `pN_rdata_valid` pulse occurs.

Source files
------------

// File: rtl/ddr_sdram_arb_pkg.sv
// Shared types and default widths for the DDR SDRAM local-interface arbiter.
package ddr_sdram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 22;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_BE_W   = 8;

  // Requester identifier (two ports).
  typedef logic port_id_t;

  // Type of the command held in the command stage.
  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_type_e;

endpackage

// File: rtl/ddr_sdram_arb_fifo.sv
// Synchronous FIFO with full/empty flags and occupancy count.
// Pop is evaluated before push, so a full FIFO accepts a push in a cycle that also pops.
module ddr_sdram_arb_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ddr_sdram_local_arbiter.sv
// Two-port arbiter for the DDR SDRAM controller local interface.
// Define DDR_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0).
module ddr_sdram_local_arbiter
  import ddr_sdram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BE_W     = DEF_BE_W,
  parameter int unsigned RD_DEPTH = 8,
  parameter int unsigned WR_DEPTH = 8
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk,
  input  logic              p0_read_req,
  input  logic              p0_write_req,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [BE_W-1:0]   p0_be,
  output logic              p0_ready,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rdata_valid,
  input  logic              p1_read_req,
  input  logic              p1_write_req,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [BE_W-1:0]   p1_be,
  output logic              p1_ready,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rdata_valid,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic              local_read_req,
  output logic              local_write_req,
  output logic              local_burstbegin,
  output logic [ADDR_W-1:0] local_address,
  output logic              local_size,
  input  logic              local_wdata_req,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  input  logic [DATA_W-1:0] local_rdata,
  input  logic              local_rdata_valid,
  output logic              err_orphan_rdata
);

  localparam int unsigned WrW = DATA_W + BE_W;

  // Command stage
  logic              cmd_v_q, cmd_v_d;
  cmd_type_e         cmd_type_q, cmd_type_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              cmd_ld;

  // Arbitration
  logic     req0, req1, elig0, elig1, gnt0, gnt1, acc;
  logic     sel_rd;
  port_id_t sel_port;

  // FIFOs
  logic                    rd_full, rd_empty;
  port_id_t                rd_head;
  logic [$clog2(RD_DEPTH):0] rd_count_unused;
  logic                    wr_full, wr_empty;
  logic [WrW-1:0]          wr_push_data, wr_head;
  logic [$clog2(WR_DEPTH):0] wr_count_unused;

  // Return / write-beat registers
  logic              p0_rvalid_q, p1_rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;

  assign cmd_ld = ~cmd_v_q | local_ready;
  assign req0   = p0_read_req | p0_write_req;
  assign req1   = p1_read_req | p1_write_req;
  assign elig0  = req0 & local_init_done & cmd_ld & (p0_read_req ? ~rd_full : ~wr_full);
  assign elig1  = req1 & local_init_done & cmd_ld & (p1_read_req ? ~rd_full : ~wr_full);

`ifdef DDR_ARB_ROUND_ROBIN_EN
  port_id_t rr_q;

  // Round-robin grant: rr_q names the port holding priority this cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rr_q == 1'b0) begin
      gnt0 = elig0;
      gnt1 = elig1 & ~elig0;
    end else begin
      gnt1 = elig1;
      gnt0 = elig0 & ~elig1;
    end
  end

  // Priority moves to the port not granted, only on an accepted request.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) rr_q <= 1'b0;
    else if (acc)      rr_q <= ~sel_port;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not requesting at all.
  always_comb begin
    gnt0 = elig0;
    gnt1 = elig1 & ~req0;
  end
`endif

  assign p0_ready     = gnt0;
  assign p1_ready     = gnt1;
  assign acc          = gnt0 | gnt1;
  assign sel_port     = gnt1;
  assign sel_rd       = gnt1 ? p1_read_req : p0_read_req;
  assign wr_push_data = gnt1 ? {p1_wdata, p1_be} : {p0_wdata, p0_be};

  // Command stage next state: load on accept, otherwise retire on local_ready.
  always_comb begin
    cmd_v_d    = cmd_v_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    if (acc) begin
      cmd_v_d    = 1'b1;
      cmd_type_d = sel_rd ? CMD_RD : CMD_WR;
      cmd_addr_d = gnt1 ? p1_address : p0_address;
    end else if (local_ready) begin
      cmd_v_d = 1'b0;
    end
  end

  // Command stage register.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      cmd_v_q    <= 1'b0;
      cmd_type_q <= CMD_RD;
      cmd_addr_q <= '0;
    end else begin
      cmd_v_q    <= cmd_v_d;
      cmd_type_q <= cmd_type_d;
      cmd_addr_q <= cmd_addr_d;
    end
  end

  assign local_read_req   = cmd_v_q & (cmd_type_q == CMD_RD);
  assign local_write_req  = cmd_v_q & (cmd_type_q == CMD_WR);
  assign local_burstbegin = cmd_v_q;
  assign local_address    = cmd_addr_q;
  assign local_size       = 1'b1;

  ddr_sdram_arb_fifo #(
    .Width (1),
    .Depth (RD_DEPTH)
  ) u_rd_tag_fifo (
    .clk_i   (phy_clk),
    .rst_i   (reset_phy_clk),
    .push_i  (acc & sel_rd),
    .pop_i   (local_rdata_valid),
    .wdata_i (sel_port),
    .rdata_o (rd_head),
    .full_o  (rd_full),
    .empty_o (rd_empty),
    .count_o (rd_count_unused)
  );

  ddr_sdram_arb_fifo #(
    .Width (WrW),
    .Depth (WR_DEPTH)
  ) u_wr_data_fifo (
    .clk_i   (phy_clk),
    .rst_i   (reset_phy_clk),
    .push_i  (acc & ~sel_rd),
    .pop_i   (local_wdata_req),
    .wdata_i (wr_push_data),
    .rdata_o (wr_head),
    .full_o  (wr_full),
    .empty_o (wr_empty),
    .count_o (wr_count_unused)
  );

  // Read return routing by tag; orphan beats are dropped and flagged (sticky).
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      p0_rvalid_q <= local_rdata_valid & ~rd_empty & (rd_head == 1'b0);
      p1_rvalid_q <= local_rdata_valid & ~rd_empty & (rd_head == 1'b1);
      if (local_rdata_valid & ~rd_empty) rdata_q <= local_rdata;
      if (local_rdata_valid & rd_empty)  err_q   <= 1'b1;
    end
  end

  assign p0_rdata_valid   = p0_rvalid_q;
  assign p1_rdata_valid   = p1_rvalid_q;
  assign p0_rdata         = rdata_q;
  assign p1_rdata         = rdata_q;
  assign err_orphan_rdata = err_q;

  // Write beat presented the cycle after local_wdata_req; zero when nothing was popped.
  always_ff @(posedge phy_clk) begin
    if (reset_phy_clk) begin
      wdata_q <= '0;
      be_q    <= '0;
    end else if (local_wdata_req & ~wr_empty) begin
      {wdata_q, be_q} <= wr_head;
    end else begin
      wdata_q <= '0;
      be_q    <= '0;
    end
  end

  assign local_wdata = wdata_q;
  assign local_be    = be_q;

endmodule
